riscv_dmem_unit: RTL
====================

// Module: riscv_dmem_unit
// PURPOSE
// - Parametrised RV32I data-memory unit. Executes LB/LH/LW/LBU/LHU/SB/SH/SW on a byte-addressed,
//   little-endian, word-organised RAM behind a valid/ready request and a one-cycle response pulse.
// - Sits between the datapath's execute stage (address = ALU result) and writeback.
// - Adds over the fixed-size memory: configurable read latency, byte enables, sign/zero extension,
//   misalignment and illegal-funct3 detection.
// PARAMETERS
// - ADDR_WIDTH   16   byte-address width; RAM holds 2**ADDR_WIDTH bytes (default 65536 = MEM_SIZE)
// - DATA_WIDTH   32   word width; fixed at REG_WIDTH, and only 32 is supported
// - RD_LATENCY   1    cycles from load accept to rsp_valid; legal range 1..4
// PORTS
// - clk          in   1             rising-edge clock
// - rst_n        in   1             asynchronous active-low reset
// - req_valid    in   1             request present
// - req_ready    out  1             unit can accept; a request transfers on req_valid && req_ready
// - req_we       in   1             1 = store, 0 = load
// - req_funct3   in   3             RV32I funct3 (LB=000 LH=001 LW=010 LBU=100 LHU=101; SB=000 SH=001 SW=010)
// - req_addr     in   ADDR_WIDTH    byte address
// - req_wdata    in   DATA_WIDTH    store data; the low byte or half is used for SB/SH
// - rsp_valid    out  1             one-cycle pulse; response for the oldest accepted request
// - rsp_rdata    out  DATA_WIDTH    extended load data; 0 for stores and for errors
// - rsp_err      out  1             qualified by rsp_valid: misaligned access or illegal funct3
// - busy         out  1             request in flight (equals ~req_ready out of reset)
// BEHAVIOUR
// - Reset (async, rst_n=0): FSM->IDLE; req_ready=0 while rst_n=0, then 1; rsp_valid=0; rsp_rdata=0; rsp_err=0; busy=0.
//   RAM contents are not reset.
// - FSM IDLE: req_ready=1. On accept, capture we/funct3/addr/wdata.
//   - Error -> RESP, with the error flagged.
//   - Store -> the RAM write commits at the accept edge, then RESP.
//   - Load -> WAIT; latency counter loaded with RD_LATENCY-1.
// - FSM WAIT: counter decrements each cycle; at 0 -> RESP. req_ready=0.
// - FSM RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready=0.
// - Throughput and latency:
//   - Stores and errors: rsp_valid 1 cycle after accept.
//   - Loads: rsp_valid RD_LATENCY cycles after accept.
//   - Next accept is possible in the cycle after rsp_valid.
// - Byte enables: be = SB: 4'b0001<<addr[1:0]; SH: 4'b0011<<addr[1:0]; SW: 4'b1111.
//   Write data is replicated across lanes.
// - Word index = addr[ADDR_WIDTH-1:2]. The address wraps naturally within 2**ADDR_WIDTH; no out-of-range error.
// - Load extraction: select the byte/half by addr[1:0]. LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
// - Errors (rsp_err=1, rsp_rdata=0, no RAM write):
//   - LH/LHU/SH with addr[0]=1.
//   - LW/SW with addr[1:0]!=0.
//   - Load funct3 in {011,110,111}; store funct3 >= 011.
// - rsp_rdata/rsp_err hold their value between pulses; they are only meaningful while rsp_valid=1.
// - req_valid while req_ready=0 is ignored; the requester must hold it until accepted.
// - Reset mid-operation: the pending response is discarded (no rsp_valid). A store that committed before reset stays in RAM.
// - Read-after-write: a load accepted in the cycle after a store response returns the new data.
// STRUCTURE
// - RISCV_PKG additions:
//   - typedef enum logic[2:0] for load/store funct3 codes.
//   - DMEM_ADDR_WIDTH = 16 and DMEM_RD_LATENCY = 1.
//   - typedef logic[3:0] byte_en_t.
// - One sub-module, dmem_ram_bank: synchronous single-port RAM, byte-enabled write,
//   registered read (1 cycle); the remaining latency is padded in the FSM.
// - Top level: FSM, latency counter, byte-enable/align logic, extension mux.
// TESTING
// - SW 0xDEADBEEF @0x0010, then LW @0x0010 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid RD_LATENCY cycles after accept.
// - After the above: LB @0x0013 -> 0xFFFFFFDE; LBU @0x0013 -> 0x000000DE; LH @0x0012 -> 0xFFFFDEAD; LHU @0x0010 -> 0x0000BEEF.
// - SB wdata=0x12345655 @0x0011, then LW @0x0010 -> 0xDEAD55EF (only byte 1 changed).
// - SH @0x0011 and LW @0x0012 -> rsp_err=1, rsp_rdata=0; a following LW @0x0010 still returns 0xDEAD55EF.
// - Illegal load funct3=3'b011 -> rsp_err=1 one cycle after accept.
// - RD_LATENCY=3: LW accept, assert rst_n=0 on cycle 2 -> no rsp_valid; req_ready=0 while rst_n=0, then 1;
//   RAM keeps 0xDEAD55EF.
// - Back-to-back req_valid held high: each accept separated by its full latency plus one cycle; no request lost or duplicated.

Source files
------------

// File: rtl/riscv_dmem_unit_pkg.sv
// Shared types and defaults for the RV32I data-memory unit.
// - ls_funct3_e : load/store funct3 encodings (stores use B/H/W only)
// - byte_en_t   : per-lane write enable for one 32-bit word
// - helpers     : access error detection and byte-enable generation
package riscv_dmem_unit_pkg;

  localparam int DMEM_ADDR_WIDTH = 16;
  localparam int DMEM_DATA_WIDTH = 32;
  localparam int DMEM_RD_LATENCY = 1;

  typedef logic [3:0] byte_en_t;

  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } ls_funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Misaligned half/word, unknown load funct3, or a store using an unsigned code.
  function automatic logic access_err(logic we, logic [2:0] f3, logic [1:0] off);
    logic err;
    err = 1'b0;
    case (f3)
      LS_B:    err = 1'b0;
      LS_H:    err = off[0];
      LS_W:    err = |off;
      LS_BU:   err = we;
      LS_HU:   err = we | off[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic byte_en_t byte_enable(logic [2:0] f3, logic [1:0] off);
    byte_en_t be;
    case (f3[1:0])
      2'b00:   be = byte_en_t'(4'b0001 << off);
      2'b01:   be = byte_en_t'(4'b0011 << off);
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/riscv_dmem_unit_if.sv
// Request/response bundle between the execute stage and the data-memory unit.
// - master : requester side (drives req_*, observes ready and response)
// - slave  : memory unit side
interface riscv_dmem_unit_if
  import riscv_dmem_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  busy;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/riscv_dmem_unit_ram_bank.sv
// Single-port word RAM with byte-lane write enables and a registered read.
// - clk   : rising-edge clock
// - en    : access enable
// - we    : 1 = write lanes selected by be, 0 = read into rdata
// - be    : byte-lane enables
// - addr  : word index
// - wdata : write data (already lane-replicated)
// - rdata : read data, valid the cycle after a read; holds otherwise
// Contents are intentionally not reset.
module riscv_dmem_unit_ram_bank
  import riscv_dmem_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH - 2,
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  byte_en_t              be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/riscv_dmem_unit.sv
// RV32I data-memory unit: LB/LH/LW/LBU/LHU/SB/SH/SW over a byte-enabled word RAM.
// - clk   : rising-edge clock
// - rst_n : asynchronous active-low reset
// - bus   : request (valid/ready, we, funct3, addr, wdata), one-cycle response
//           pulse (rsp_valid, rsp_rdata, rsp_err) and busy
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request
// WAIT    | load in flight; down-counter pads RAM latency to RD_LATENCY
// RESP    | rsp_valid asserted for this single cycle
module riscv_dmem_unit
  import riscv_dmem_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int RD_LATENCY = DMEM_RD_LATENCY
) (
  input logic              clk,
  input logic              rst_n,
  riscv_dmem_unit_if.slave bus
);

  localparam logic [1:0] LAT_INIT = 2'(RD_LATENCY - 1);

  dmem_state_e           state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic                  err_q;
  logic                  load_q;
  logic [DATA_WIDTH-1:0] rdata_hold_q;
  logic                  err_hold_q;

  logic                  accept;
  logic [1:0]            req_off;
  logic                  req_err;
  byte_en_t              req_be;
  logic [DATA_WIDTH-1:0] wdata_rep;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [DATA_WIDTH-1:0] ext_data;
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;

  assign accept  = bus.req_valid & bus.req_ready;
  assign req_off = bus.req_addr[1:0];
  assign req_err = access_err(bus.req_we, bus.req_funct3, req_off);
  assign req_be  = byte_enable(bus.req_funct3, req_off);

  always_comb begin
    case (bus.req_funct3[1:0])
      2'b00:   wdata_rep = {4{bus.req_wdata[7:0]}};
      2'b01:   wdata_rep = {2{bus.req_wdata[15:0]}};
      default: wdata_rep = bus.req_wdata;
    endcase
  end

  // Stores commit and loads sample the RAM on the accept edge itself.
  riscv_dmem_unit_ram_bank #(
    .ADDR_WIDTH(ADDR_WIDTH - 2),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (accept & ~req_err),
    .we    (bus.req_we),
    .be    (req_be),
    .addr  (bus.req_addr[ADDR_WIDTH-1:2]),
    .wdata (wdata_rep),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      f3_q         <= '0;
      off_q        <= '0;
      err_q        <= 1'b0;
      load_q       <= 1'b0;
      rdata_hold_q <= '0;
      err_hold_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        f3_q   <= bus.req_funct3;
        off_q  <= req_off;
        err_q  <= req_err;
        load_q <= ~bus.req_we;
      end
      if (state_q == ST_RESP) begin
        rdata_hold_q <= ext_data;
        err_hold_q   <= err_q;
      end
    end
  end

  // The counter reaches zero on the edge entering RESP, so RESP lands exactly
  // RD_LATENCY cycles after accept; latency 1 skips WAIT entirely.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d = LAT_INIT;
          if (req_err || bus.req_we || RD_LATENCY == 1) state_d = ST_RESP;
          else                                           state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign sel_byte = ram_rdata[{off_q, 3'b000} +: 8];
  assign sel_half = ram_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    ext_data = '0;
    if (load_q && !err_q) begin
      case (f3_q)
        LS_B:    ext_data = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
        LS_BU:   ext_data = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
        LS_H:    ext_data = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
        LS_HU:   ext_data = {{(DATA_WIDTH-16){1'b0}}, sel_half};
        LS_W:    ext_data = ram_rdata;
        default: ext_data = '0;
      endcase
    end
  end

  // Ready is forced low while reset is asserted, not just after it.
  assign bus.req_ready = rst_n & (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = bus.rsp_valid ? ext_data : rdata_hold_q;
  assign bus.rsp_err   = bus.rsp_valid ? err_q : err_hold_q;

endmodule
